// File: rtl/sw_debounce_pkg.sv
// sw_debounce_pkg: shared constants and helpers for the switch debouncer.
//   DB_CYCLES_DEFAULT : stable cycles to accept a change (20 ms at 50 MHz)
//   DB_CYCLES_SIM     : short debounce window used in simulation
//   NCH_DEFAULT       : number of switch channels on the board
package sw_debounce_pkg;
    localparam int DB_CYCLES_DEFAULT = 1000000;
    localparam int DB_CYCLES_SIM     = 4;
    localparam int NCH_DEFAULT       = 10;

    // Counter width holding 0..db_cycles-1, never narrower than one bit.
    function automatic int cnt_width(input int db_cycles);
        return (db_cycles > 1) ? $clog2(db_cycles) : 1;
    endfunction
endpackage

// File: rtl/debounce_channel.sv
// debounce_channel: one switch channel -- 2-flop synchroniser plus stability counter.
//   clk    : system clock (rising edge)
//   rst_n  : asynchronous active-low reset
//   sw     : raw asynchronous switch level
//   stable : current accepted level (held by the parent's output register)
//   flip   : high when the accepted level must invert on the coming edge
module debounce_channel
    import sw_debounce_pkg::*;
#(
    parameter int DB_CYCLES = DB_CYCLES_DEFAULT
) (
    input  logic clk,
    input  logic rst_n,
    input  logic sw,
    input  logic stable,
    output logic flip
);
    localparam int CW = cnt_width(DB_CYCLES);
    localparam logic [CW-1:0] LAST = CW'(DB_CYCLES - 1);

    logic          s1;
    logic          s2;
    logic          mismatch;
    logic [CW-1:0] cnt;

    assign mismatch = s2 != stable;
    assign flip     = mismatch && (cnt == LAST);

    // Any cycle where s2 agrees with the accepted level restarts the window,
    // so a change is accepted only after DB_CYCLES consecutive mismatches.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1  <= 1'b0;
            s2  <= 1'b0;
            cnt <= '0;
        end else begin
            s1  <= sw;
            s2  <= s1;
            cnt <= (mismatch && !flip) ? cnt + 1'b1 : '0;
        end
    end
endmodule

// File: rtl/sw_debounce.sv
// sw_debounce: multi-channel switch debouncer with per-channel edge pulses.
//   CLOCK_50   : system clock (rising edge)
//   Resetn     : asynchronous active-low reset
//   SW         : raw switch levels
//   SW_db      : debounced levels
//   SW_rise    : one-cycle pulse when SW_db goes 0->1
//   SW_fall    : one-cycle pulse when SW_db goes 1->0
//   any_change : high in any cycle carrying a rise or fall pulse
module sw_debounce
    import sw_debounce_pkg::*;
#(
    parameter int DB_CYCLES = DB_CYCLES_DEFAULT,
    parameter int NCH       = NCH_DEFAULT
) (
    input  logic           CLOCK_50,
    input  logic           Resetn,
    input  logic [NCH-1:0] SW,
    output logic [NCH-1:0] SW_db,
    output logic [NCH-1:0] SW_rise,
    output logic [NCH-1:0] SW_fall,
    output logic           any_change
);
    logic [NCH-1:0] flip;

    for (genvar i = 0; i < NCH; i++) begin : g_ch
        debounce_channel #(.DB_CYCLES(DB_CYCLES)) u_ch (
            .clk    (CLOCK_50),
            .rst_n  (Resetn),
            .sw     (SW[i]),
            .stable (SW_db[i]),
            .flip   (flip[i])
        );
    end

    // Pulses are derived from the pre-edge level so they land on the same
    // edge as the SW_db update; any_change is built from the same flips.
    always_ff @(posedge CLOCK_50 or negedge Resetn) begin
        if (!Resetn) begin
            SW_db      <= '0;
            SW_rise    <= '0;
            SW_fall    <= '0;
            any_change <= 1'b0;
        end else begin
            SW_db      <= SW_db ^ flip;
            SW_rise    <= flip & ~SW_db;
            SW_fall    <= flip & SW_db;
            any_change <= |flip;
        end
    end
endmodule

// File: tb/tb_sw_debounce.sv
// tb_sw_debounce: table-driven, directed and randomized checks of sw_debounce.
module tb_sw_debounce;
    import sw_debounce_pkg::*;

    localparam int DB = DB_CYCLES_SIM;
    localparam int N  = NCH_DEFAULT;

    logic         CLOCK_50 = 1'b0;
    logic         Resetn   = 1'b0;
    logic [N-1:0] SW       = '0;
    logic [N-1:0] SW_db;
    logic [N-1:0] SW_rise;
    logic [N-1:0] SW_fall;
    logic         any_change;

    int compared   = 0;
    int mismatched = 0;

    // Reference: per channel, a two-stage delay line and the length of the
    // current run of disagreeing samples; a run of DB accepts the new level.
    logic [N-1:0] m_s1, m_s2, m_db, m_rise, m_fall;
    logic         m_any;
    int           run [N];

    typedef struct {
        logic [N-1:0] sw;
        int           cycles;
        logic [N-1:0] db;
        logic [N-1:0] rise;
        logic [N-1:0] fall;
    } vec_t;

    vec_t tbl [11];

    sw_debounce #(.DB_CYCLES(DB), .NCH(N)) dut (
        .CLOCK_50   (CLOCK_50),
        .Resetn     (Resetn),
        .SW         (SW),
        .SW_db      (SW_db),
        .SW_rise    (SW_rise),
        .SW_fall    (SW_fall),
        .any_change (any_change)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    task automatic check(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_s1 = '0; m_s2 = '0; m_db = '0; m_rise = '0; m_fall = '0; m_any = 1'b0;
        for (int c = 0; c < N; c++) run[c] = 0;
    endtask

    task automatic model_edge();
        for (int c = 0; c < N; c++) begin
            m_rise[c] = 1'b0;
            m_fall[c] = 1'b0;
            run[c] = (m_s2[c] != m_db[c]) ? run[c] + 1 : 0;
            if (run[c] == DB) begin
                m_db[c] = ~m_db[c];
                run[c]  = 0;
                if (m_db[c]) m_rise[c] = 1'b1;
                else         m_fall[c] = 1'b1;
            end
        end
        m_any = |(m_rise | m_fall);
        m_s2  = m_s1;
        m_s1  = SW;
    endtask

    task automatic check_all(input string tag);
        check({tag, ".db"},   SW_db,   m_db);
        check({tag, ".rise"}, SW_rise, m_rise);
        check({tag, ".fall"}, SW_fall, m_fall);
        check({tag, ".any"},  N'(any_change), N'(m_any));
        check({tag, ".excl"}, SW_rise & SW_fall, '0);
    endtask

    task automatic tick();
        @(posedge CLOCK_50);
        if (Resetn) model_edge();
        #1;
        check_all("model");
    endtask

    // Called at posedge+1: asserts reset between edges, checks the immediate
    // clear, holds across one edge, releases before the next edge.
    task automatic pulse_reset();
        #3;
        Resetn = 1'b0;
        model_reset();
        #1;
        check_all("async_rst");
        tick();
        #2;
        Resetn = 1'b1;
    endtask

    initial begin
        tbl[0]  = '{sw: 10'h000, cycles: 3, db: 10'h000, rise: 10'h000, fall: 10'h000};
        tbl[1]  = '{sw: 10'h008, cycles: 5, db: 10'h000, rise: 10'h000, fall: 10'h000};
        tbl[2]  = '{sw: 10'h008, cycles: 1, db: 10'h008, rise: 10'h008, fall: 10'h000};
        tbl[3]  = '{sw: 10'h008, cycles: 1, db: 10'h008, rise: 10'h000, fall: 10'h000};
        tbl[4]  = '{sw: 10'h009, cycles: 3, db: 10'h008, rise: 10'h000, fall: 10'h000};
        tbl[5]  = '{sw: 10'h008, cycles: 8, db: 10'h008, rise: 10'h000, fall: 10'h000};
        tbl[6]  = '{sw: 10'h000, cycles: 6, db: 10'h000, rise: 10'h000, fall: 10'h008};
        tbl[7]  = '{sw: 10'h203, cycles: 6, db: 10'h203, rise: 10'h203, fall: 10'h000};
        tbl[8]  = '{sw: 10'h203, cycles: 1, db: 10'h203, rise: 10'h000, fall: 10'h000};
        tbl[9]  = '{sw: 10'h000, cycles: 6, db: 10'h000, rise: 10'h000, fall: 10'h203};
        tbl[10] = '{sw: 10'h000, cycles: 1, db: 10'h000, rise: 10'h000, fall: 10'h000};

        model_reset();
        repeat (2) @(posedge CLOCK_50);
        #1;
        check_all("reset");
        #2;
        Resetn = 1'b1;

        for (int v = 0; v < 11; v++) begin
            SW = tbl[v].sw;
            repeat (tbl[v].cycles) tick();
            check($sformatf("tbl%0d.db", v),   SW_db,   tbl[v].db);
            check($sformatf("tbl%0d.rise", v), SW_rise, tbl[v].rise);
            check($sformatf("tbl%0d.fall", v), SW_fall, tbl[v].fall);
            check($sformatf("tbl%0d.any", v),  N'(any_change), N'(|(tbl[v].rise | tbl[v].fall)));
        end

        // Bounce on SW[9]: only the final level survives, one pulse 6 edges later.
        for (int b = 0; b < 4; b++) begin
            SW = b[0] ? 10'h000 : 10'h200;
            tick();
            check("bounce.quiet", SW_rise | SW_fall, '0);
        end
        SW = 10'h200;
        repeat (5) tick();
        check("bounce.early", SW_rise, '0);
        tick();
        check("bounce.rise", SW_rise, 10'h200);
        check("bounce.db",   SW_db,   10'h200);
        SW = 10'h000;
        repeat (8) tick();

        // Reset in the middle of a count discards it; full latency again after.
        SW = 10'h002;
        repeat (3) tick();
        pulse_reset();
        repeat (5) tick();
        check("rst_mid.early", SW_db, '0);
        tick();
        check("rst_mid.db", SW_db, 10'h002);
        check("rst_mid.rise", SW_rise, 10'h002);

        // Reset with a non-zero debounced level must clear it without an edge.
        repeat (2) tick();
        pulse_reset();
        check("rst_async.db", SW_db, '0);
        repeat (6) tick();
        check("rst_async.relatch", SW_db, 10'h002);

        // Downstream select/AND/OR path driven by the debounced levels.
        for (int k = 0; k < 8; k++) begin
            logic [2:0] bits;
            logic       ledr;
            bits = 3'(k);
            SW = {bits[2], 7'b0, bits[1], bits[0]};
            repeat (7) tick();
            ledr = (~SW_db[9] & SW_db[0]) | (SW_db[9] & SW_db[1]);
            check($sformatf("ledr%0d", k), N'(ledr), N'(bits[2] ? bits[1] : bits[0]));
        end

        // Random hold lengths straddling the debounce window.
        for (int r = 0; r < 120; r++) begin
            SW = N'($urandom);
            repeat ($urandom_range(1, 8)) tick();
            if (r == 60) pulse_reset();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
